instr_mem_loadable: RTL and testbench

Parametrised, synchronous-read instruction memory for the ARM core's fetch stage. Supports configurable depth and base address. A serial program-load port lets a bench or boot controller fill the array at run time instead of relying on hard-coded contents. Fetches use a one-cycle registered req/valid handshake with alignment and range fault reporting.

---
 rtl/instr_mem_loadable.sv | 124 ++++++++++++
 tb/tb_instr_mem_loadable.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - loadable synchronous-read instruction memory with fetch fault reporting
// A serial load port fills the array; fetches return one registered word per accepted request.
module instr_mem_loadable #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH_LOG2 = 7,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  FetchReq,
  input  logic [ADDR_WIDTH-1:0] PC,
  output logic                  FetchReady,
  output logic [DATA_WIDTH-1:0] Instr,
  output logic                  InstrValid,
  output logic                  Fault,
  input  logic                  ProgStart,
  input  logic                  ProgWE,
  input  logic [DATA_WIDTH-1:0] ProgData,
  input  logic                  ProgDone,
  output logic                  Loading,
  output logic [DEPTH_LOG2:0]   ProgCount,
  output logic                  ProgOverflow
);
  localparam int WORDS = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(WORDS);
  localparam logic [DEPTH_LOG2:0] LAST = (DEPTH_LOG2 + 1)'(WORDS - 1);
  localparam logic [DEPTH_LOG2:0] ONE  = (DEPTH_LOG2 + 1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic [DATA_WIDTH-1:0]   instr_q, instr_d;
  logic                    valid_q, valid_d;
  logic                    fault_q, fault_d;
  logic [DATA_WIDTH-1:0]   mem_q [WORDS];
  logic                    mem_we;
  logic                    accept;
  logic                    borrow;
  logic                    addr_fault;
  logic [ADDR_WIDTH-1:0]   offset;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [DEPTH_LOG2-1:0]   wr_idx;

  assign FetchReady = (state_q != LOAD) && !ProgStart;
  assign accept     = FetchReq && FetchReady;

  // The borrow of PC-BASE_ADDR flags addresses below the base without a constant compare.
  assign {borrow, offset} = {1'b0, PC} - {1'b0, BASE_ADDR};
  assign rd_idx     = offset[DEPTH_LOG2+1:2];
  assign addr_fault = (offset[1:0] != 2'b00) || borrow
                      || (offset[ADDR_WIDTH-1:DEPTH_LOG2+2] != '0);

  // The load pointer and ProgCount always agree, so one counter serves both.
  assign wr_idx = count_q[DEPTH_LOG2-1:0];

  always_comb begin
    valid_d = accept;
    fault_d = accept && addr_fault;
    instr_d = instr_q;
    if (accept) begin
      instr_d = addr_fault ? '0 : mem_q[rd_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;
    if (ProgStart) begin
      state_d    = LOAD;
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (state_q == LOAD) begin
      if (ProgWE && (count_q < FULL)) begin
        mem_we  = 1'b1;
        count_d = count_q + ONE;
        if (count_q == LAST) begin
          state_d = RUN;
        end
      end
      if (ProgDone) begin
        state_d = RUN;
      end
    end else if (ProgWE && (count_q == FULL)) begin
      overflow_d = 1'b1;
    end
  end

  // Array is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[wr_idx] <= ProgData;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
      instr_q    <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign Instr        = instr_q;
  assign InstrValid   = valid_q;
  assign Fault        = fault_q;
  assign Loading      = (state_q == LOAD);
  assign ProgCount    = count_q;
  assign ProgOverflow = overflow_q;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - bench for instr_mem_loadable across three configurations
// All three instances share stimulus; a word-array reference model predicts each one.
module tb_instr_mem_loadable;
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        Reset, FetchReq, ProgStart, ProgWE, ProgDone;
  logic [31:0] PC, ProgData;
  logic [2:0]  rdy, vld, flt, ldg, ovf;
  logic [31:0] ins [3];
  logic [7:0]  cnt0;
  logic [4:0]  cnt1;
  logic [2:0]  cnt2;

  instr_mem_loadable u_d0 (
    .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .PC(PC), .FetchReady(rdy[0]),
    .Instr(ins[0]), .InstrValid(vld[0]), .Fault(flt[0]), .ProgStart(ProgStart),
    .ProgWE(ProgWE), .ProgData(ProgData), .ProgDone(ProgDone), .Loading(ldg[0]),
    .ProgCount(cnt0), .ProgOverflow(ovf[0]));

  instr_mem_loadable #(.DEPTH_LOG2(4), .BASE_ADDR(32'h0000_1000)) u_d1 (
    .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .PC(PC), .FetchReady(rdy[1]),
    .Instr(ins[1]), .InstrValid(vld[1]), .Fault(flt[1]), .ProgStart(ProgStart),
    .ProgWE(ProgWE), .ProgData(ProgData), .ProgDone(ProgDone), .Loading(ldg[1]),
    .ProgCount(cnt1), .ProgOverflow(ovf[1]));

  instr_mem_loadable #(.DEPTH_LOG2(2)) u_d2 (
    .CLK(CLK), .Reset(Reset), .FetchReq(FetchReq), .PC(PC), .FetchReady(rdy[2]),
    .Instr(ins[2]), .InstrValid(vld[2]), .Fault(flt[2]), .ProgStart(ProgStart),
    .ProgWE(ProgWE), .ProgData(ProgData), .ProgDone(ProgDone), .Loading(ldg[2]),
    .ProgCount(cnt2), .ProgOverflow(ovf[2]));

  logic [31:0] m_mem [3][128];
  bit          m_wr [3][128];
  bit          m_load [3];
  int          m_count [3];
  bit          m_ovf [3];
  bit          e_vld [3];
  bit          e_flt [3];
  logic [31:0] e_ins [3];
  bit          e_known [3];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] prog [11];

  function automatic int dep_of(input int k);
    return (k == 0) ? 128 : ((k == 1) ? 16 : 4);
  endfunction

  function automatic longint base_of(input int k);
    return (k == 1) ? 64'h1000 : 64'h0;
  endfunction

  function automatic logic [7:0] cnt_of(input int k);
    return (k == 0) ? cnt0 : ((k == 1) ? {3'b000, cnt1} : {5'b00000, cnt2});
  endfunction

  task automatic set_idle();
    Reset = 1'b0; FetchReq = 1'b0; PC = '0; ProgStart = 1'b0;
    ProgWE = 1'b0; ProgDone = 1'b0; ProgData = '0;
  endtask

  // Advances the reference model by one clock using the inputs the DUTs see at this edge.
  task automatic tick();
    for (int k = 0; k < 3; k++) begin
      longint off;
      int     dep;
      dep = dep_of(k);
      off = longint'(PC) - base_of(k);
      if (Reset) begin
        e_vld[k] = 0; e_flt[k] = 0; e_ins[k] = '0; e_known[k] = 1;
        m_load[k] = 0; m_count[k] = 0; m_ovf[k] = 0;
      end else begin
        if (FetchReq && !m_load[k] && !ProgStart) begin
          e_vld[k] = 1;
          e_flt[k] = (PC[1:0] != 2'b00) || (off < 0) || (off >= 4 * dep);
          if (e_flt[k]) begin
            e_ins[k] = '0; e_known[k] = 1;
          end else begin
            e_ins[k] = m_mem[k][int'(off / 4)];
            e_known[k] = m_wr[k][int'(off / 4)];
          end
        end else begin
          e_vld[k] = 0; e_flt[k] = 0;
        end
        if (ProgStart) begin
          m_load[k] = 1; m_count[k] = 0; m_ovf[k] = 0;
        end else if (m_load[k]) begin
          if (ProgWE && m_count[k] < dep) begin
            m_mem[k][m_count[k]] = ProgData;
            m_wr[k][m_count[k]] = 1;
            m_count[k]++;
            if (m_count[k] == dep) m_load[k] = 0;
          end
          if (ProgDone) m_load[k] = 0;
        end else if (ProgWE && m_count[k] == dep) begin
          m_ovf[k] = 1;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    set_idle();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks += 6;
      if (vld[k] !== 1'b0) begin n_errors++; $display("FAIL reset_valid k=%0d got %b exp 0", k, vld[k]); end
      if (flt[k] !== 1'b0) begin n_errors++; $display("FAIL reset_fault k=%0d got %b exp 0", k, flt[k]); end
      if (ins[k] !== 32'h0) begin n_errors++; $display("FAIL reset_instr k=%0d got %h exp 0", k, ins[k]); end
      if (ldg[k] !== 1'b0) begin n_errors++; $display("FAIL reset_loading k=%0d got %b exp 0", k, ldg[k]); end
      if (cnt_of(k) !== 8'd0) begin n_errors++; $display("FAIL reset_count k=%0d got %0d exp 0", k, cnt_of(k)); end
      if (rdy[k] !== 1'b1) begin n_errors++; $display("FAIL reset_ready k=%0d got %b exp 1", k, rdy[k]); end
    end
    n_checks++;
    if (ovf !== 3'b000) begin n_errors++; $display("FAIL reset_overflow got %b exp 000", ovf); end
  endtask

  task automatic test_load_program();
    prog = '{32'hE2000000, 32'hE5900001, 32'hE5900000, 32'hE0E02000, 32'hE2811001,
             32'hE3510004, 32'h1AFFFFFA, 32'hE0803001, 32'hE5803000, 32'hE2422001,
             32'hE1C15000};
    set_idle();
    ProgStart = 1'b1;
    #1;
    n_checks++;
    if (rdy !== 3'b000) begin n_errors++; $display("FAIL ready_during_progstart got %b exp 000", rdy); end
    tick();
    ProgStart = 1'b0;
    n_checks++;
    if (ldg !== 3'b111) begin n_errors++; $display("FAIL loading_after_start got %b exp 111", ldg); end
    for (int i = 0; i < 11; i++) begin
      ProgWE = 1'b1; ProgData = prog[i];
      tick();
      n_checks++;
      if (cnt0 !== 8'(i + 1)) begin n_errors++; $display("FAIL load_count0 got %0d exp %0d", cnt0, i + 1); end
      for (int k = 1; k < 3; k++) begin
        n_checks += 2;
        if (cnt_of(k) !== 8'(m_count[k])) begin n_errors++; $display("FAIL load_count k=%0d got %0d exp %0d", k, cnt_of(k), m_count[k]); end
        if (ovf[k] !== m_ovf[k]) begin n_errors++; $display("FAIL load_overflow k=%0d got %b exp %b", k, ovf[k], m_ovf[k]); end
      end
    end
    ProgWE = 1'b0; ProgDone = 1'b1;
    tick();
    ProgDone = 1'b0;
    n_checks += 5;
    if (ldg !== 3'b000) begin n_errors++; $display("FAIL loading_after_done got %b exp 000", ldg); end
    if (cnt0 !== 8'd11) begin n_errors++; $display("FAIL done_count0 got %0d exp 11", cnt0); end
    if (cnt1 !== 5'd11) begin n_errors++; $display("FAIL done_count1 got %0d exp 11", cnt1); end
    if (cnt2 !== 3'd4) begin n_errors++; $display("FAIL autorun_count2 got %0d exp 4", cnt2); end
    if (ovf !== 3'b100) begin n_errors++; $display("FAIL overflow_flags got %b exp 100", ovf); end
  endtask

  task automatic test_fetch_back_to_back();
    logic [31:0] pcs [3];
    logic [31:0] exp_w [3];
    pcs = '{32'h0, 32'h4, 32'h28};
    exp_w = '{prog[0], prog[1], prog[10]};
    set_idle();
    FetchReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      PC = pcs[i];
      tick();
      n_checks += 3;
      if (vld[0] !== 1'b1) begin n_errors++; $display("FAIL b2b_valid pc=%h got %b exp 1", pcs[i], vld[0]); end
      if (flt[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_fault pc=%h got %b exp 0", pcs[i], flt[0]); end
      if (ins[0] !== exp_w[i]) begin n_errors++; $display("FAIL b2b_instr pc=%h got %h exp %h", pcs[i], ins[0], exp_w[i]); end
      for (int k = 1; k < 3; k++) begin
        n_checks += 2;
        if (vld[k] !== e_vld[k]) begin n_errors++; $display("FAIL b2b_valid k=%0d got %b exp %b", k, vld[k], e_vld[k]); end
        if (flt[k] !== e_flt[k]) begin n_errors++; $display("FAIL b2b_fault k=%0d got %b exp %b", k, flt[k], e_flt[k]); end
      end
    end
    FetchReq = 1'b0;
    tick();
    n_checks += 3;
    if (vld !== 3'b000) begin n_errors++; $display("FAIL idle_valid got %b exp 000", vld); end
    if (flt !== 3'b000) begin n_errors++; $display("FAIL idle_fault got %b exp 000", flt); end
    if (ins[0] !== prog[10]) begin n_errors++; $display("FAIL instr_hold got %h exp %h", ins[0], prog[10]); end
  endtask

  task automatic test_fault_default();
    logic [31:0] pcs [2];
    pcs = '{32'h6, 32'h200};
    set_idle();
    FetchReq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      PC = pcs[i];
      tick();
      n_checks += 3;
      if (vld[0] !== 1'b1) begin n_errors++; $display("FAIL fault_valid pc=%h got %b exp 1", pcs[i], vld[0]); end
      if (flt[0] !== 1'b1) begin n_errors++; $display("FAIL fault_flag pc=%h got %b exp 1", pcs[i], flt[0]); end
      if (ins[0] !== 32'h0) begin n_errors++; $display("FAIL fault_instr pc=%h got %h exp 0", pcs[i], ins[0]); end
    end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_load_blocks_fetch();
    set_idle();
    ProgStart = 1'b1;
    tick();
    ProgStart = 1'b0; ProgWE = 1'b1; ProgData = 32'h1111_2222;
    tick();
    ProgWE = 1'b0;
    FetchReq = 1'b1; PC = 32'h0;
    #1;
    n_checks += 2;
    if (cnt0 !== 8'd1) begin n_errors++; $display("FAIL prestart_count got %0d exp 1", cnt0); end
    if (rdy !== 3'b000) begin n_errors++; $display("FAIL ready_in_load got %b exp 000", rdy); end
    tick();
    FetchReq = 1'b0;
    n_checks++;
    if (vld !== 3'b000) begin n_errors++; $display("FAIL valid_in_load got %b exp 000", vld); end
    ProgStart = 1'b1; ProgWE = 1'b1; ProgData = 32'hAAAA_0000;
    tick();
    ProgStart = 1'b0; ProgWE = 1'b0;
    n_checks += 2;
    if (ldg !== 3'b111) begin n_errors++; $display("FAIL restart_loading got %b exp 111", ldg); end
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (cnt_of(k) !== 8'd0) begin n_errors++; $display("FAIL restart_count k=%0d got %0d exp 0", k, cnt_of(k)); end
    end
    if (ovf !== 3'b000) begin n_errors++; $display("FAIL restart_overflow got %b exp 000", ovf); end
    ProgDone = 1'b1;
    tick();
    ProgDone = 1'b0; FetchReq = 1'b1; PC = 32'h0;
    tick();
    FetchReq = 1'b0;
    n_checks += 3;
    if (ldg !== 3'b000) begin n_errors++; $display("FAIL done_empty_loading got %b exp 000", ldg); end
    if (ins[0] !== 32'h1111_2222) begin n_errors++; $display("FAIL no_write_on_start k=0 got %h exp 11112222", ins[0]); end
    if (ins[2] !== 32'h1111_2222) begin n_errors++; $display("FAIL no_write_on_start k=2 got %h exp 11112222", ins[2]); end
  endtask

  task automatic test_random_load();
    set_idle();
    ProgStart = 1'b1;
    tick();
    ProgStart = 1'b0;
    for (int c = 0; c < 1000 && m_count[0] < 128; c++) begin
      ProgWE   = ($urandom_range(3) != 0);
      ProgData = $urandom;
      FetchReq = 1'($urandom_range(1));
      PC       = 32'($urandom_range(0, 40)) * 4;
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks += 5;
        if (cnt_of(k) !== 8'(m_count[k])) begin n_errors++; $display("FAIL rload_count k=%0d got %0d exp %0d", k, cnt_of(k), m_count[k]); end
        if (ldg[k] !== m_load[k]) begin n_errors++; $display("FAIL rload_loading k=%0d got %b exp %b", k, ldg[k], m_load[k]); end
        if (ovf[k] !== m_ovf[k]) begin n_errors++; $display("FAIL rload_overflow k=%0d got %b exp %b", k, ovf[k], m_ovf[k]); end
        if (vld[k] !== e_vld[k]) begin n_errors++; $display("FAIL rload_valid k=%0d got %b exp %b", k, vld[k], e_vld[k]); end
        if (flt[k] !== e_flt[k]) begin n_errors++; $display("FAIL rload_fault k=%0d got %b exp %b", k, flt[k], e_flt[k]); end
        if (e_known[k]) begin
          n_checks++;
          if (ins[k] !== e_ins[k]) begin n_errors++; $display("FAIL rload_instr k=%0d got %h exp %h", k, ins[k], e_ins[k]); end
        end
      end
    end
    FetchReq = 1'b0;
    ProgWE = 1'b1; ProgData = 32'hDEAD_BEEF;
    tick();
    ProgWE = 1'b0;
    n_checks += 3;
    if (cnt0 !== 8'd128) begin n_errors++; $display("FAIL full_count got %0d exp 128", cnt0); end
    if (ldg !== 3'b000) begin n_errors++; $display("FAIL full_autorun got %b exp 000", ldg); end
    if (ovf !== 3'b111) begin n_errors++; $display("FAIL full_overflow got %b exp 111", ovf); end
  endtask

  task automatic test_base_range();
    logic [31:0] pcs [7];
    bit          f0 [7];
    bit          f1 [7];
    pcs = '{32'h0FFC, 32'h103C, 32'h1040, 32'h1000, 32'h6, 32'h200, 32'h1FC};
    f0  = '{1, 1, 1, 1, 1, 1, 0};
    f1  = '{1, 0, 1, 0, 1, 1, 1};
    set_idle();
    FetchReq = 1'b1;
    for (int i = 0; i < 7; i++) begin
      PC = pcs[i];
      tick();
      n_checks += 3;
      if (vld[1:0] !== 2'b11) begin n_errors++; $display("FAIL range_valid pc=%h got %b exp 11", pcs[i], vld[1:0]); end
      if (flt[0] !== f0[i]) begin n_errors++; $display("FAIL range_fault0 pc=%h got %b exp %b", pcs[i], flt[0], f0[i]); end
      if (flt[1] !== f1[i]) begin n_errors++; $display("FAIL range_fault1 pc=%h got %b exp %b", pcs[i], flt[1], f1[i]); end
      for (int k = 0; k < 3; k++) begin
        n_checks++;
        if (ins[k] !== e_ins[k]) begin n_errors++; $display("FAIL range_instr k=%0d pc=%h got %h exp %h", k, pcs[i], ins[k], e_ins[k]); end
      end
    end
    FetchReq = 1'b0;
    tick();
  endtask

  task automatic test_random_fetch();
    set_idle();
    for (int c = 0; c < 300; c++) begin
      FetchReq = 1'($urandom_range(1));
      ProgWE   = ($urandom_range(7) == 0);
      ProgData = $urandom;
      case ($urandom_range(3))
        0: PC = 32'($urandom_range(0, 130)) * 4;
        1: PC = 32'h0FF0 + 32'($urandom_range(0, 96));
        2: PC = $urandom;
        default: PC = 32'($urandom_range(0, 511));
      endcase
      tick();
      for (int k = 0; k < 3; k++) begin
        n_checks += 3;
        if (vld[k] !== e_vld[k]) begin n_errors++; $display("FAIL rfetch_valid k=%0d got %b exp %b", k, vld[k], e_vld[k]); end
        if (flt[k] !== e_flt[k]) begin n_errors++; $display("FAIL rfetch_fault k=%0d got %b exp %b", k, flt[k], e_flt[k]); end
        if (ovf[k] !== m_ovf[k]) begin n_errors++; $display("FAIL rfetch_overflow k=%0d got %b exp %b", k, ovf[k], m_ovf[k]); end
        if (e_known[k]) begin
          n_checks++;
          if (ins[k] !== e_ins[k]) begin n_errors++; $display("FAIL rfetch_instr k=%0d got %h exp %h", k, ins[k], e_ins[k]); end
        end
      end
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w [3];
    set_idle();
    ProgStart = 1'b1;
    tick();
    ProgStart = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      ProgWE = 1'b1; ProgData = w[i];
      tick();
    end
    ProgWE = 1'b0;
    n_checks += 2;
    if (cnt0 !== 8'd3) begin n_errors++; $display("FAIL midload_count got %0d exp 3", cnt0); end
    if (ldg !== 3'b111) begin n_errors++; $display("FAIL midload_loading got %b exp 111", ldg); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    n_checks += 2;
    if (ldg !== 3'b000) begin n_errors++; $display("FAIL reset_load_state got %b exp 000", ldg); end
    if (cnt0 !== 8'd0) begin n_errors++; $display("FAIL reset_load_count got %0d exp 0", cnt0); end
    FetchReq = 1'b1; PC = 32'h8;
    tick();
    FetchReq = 1'b0;
    n_checks += 4;
    if (vld[0] !== 1'b1) begin n_errors++; $display("FAIL retained_valid got %b exp 1", vld[0]); end
    if (flt[0] !== 1'b0) begin n_errors++; $display("FAIL retained_fault got %b exp 0", flt[0]); end
    if (ins[0] !== w[2]) begin n_errors++; $display("FAIL retained_instr0 got %h exp %h", ins[0], w[2]); end
    if (ins[2] !== w[2]) begin n_errors++; $display("FAIL retained_instr2 got %h exp %h", ins[2], w[2]); end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_load[k] = 0; m_count[k] = 0; m_ovf[k] = 0;
      e_vld[k] = 0; e_flt[k] = 0; e_ins[k] = '0; e_known[k] = 0;
      for (int i = 0; i < 128; i++) begin
        m_mem[k][i] = '0; m_wr[k][i] = 0;
      end
    end
    set_idle();
    test_reset();
    test_load_program();
    test_fetch_back_to_back();
    test_fault_default();
    test_load_blocks_fetch();
    test_random_load();
    test_base_range();
    test_random_fetch();
    test_reset_mid_load();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
